// File: rtl/rtc_pkg.sv
// Shared types and constants for the time-of-day counter.
package rtc_pkg;

  localparam int unsigned SEC_MAX = 60;
  localparam int unsigned MIN_MAX = 60;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } hms_t;

  function automatic logic hms_valid(hms_t t, int unsigned hours_max);
    return (32'(t.h) < hours_max) && (32'(t.m) < MIN_MAX) && (32'(t.s) < SEC_MAX);
  endfunction

endpackage

// File: rtl/rtc_mod_counter.sv
// Modulo-MOD counter with synchronous load; o_wrap flags the MOD-1 -> 0 step so that
// counters can be chained by feeding one stage's o_wrap into the next stage's i_inc.
module rtc_mod_counter #(
  parameter int unsigned MOD = 60,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_value,
  output logic         o_wrap
);

  logic [W-1:0] r_value;

  assign o_wrap  = i_inc && (r_value == W'(MOD - 1));
  assign o_value = r_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_inc) begin
      r_value <= o_wrap ? '0 : r_value + W'(1);
    end
  end

endmodule

// File: rtl/rtc_hms_counter.sv
// Binary hh:mm:ss time-of-day counter driven by an inline clock prescaler.
// Optional alarm logic is compiled in when RTC_ALARM_EN is defined.
module rtc_hms_counter
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 5000,
  parameter int unsigned TICK_HZ   = 1,
  parameter int unsigned HOURS_MAX = 24,
  parameter int unsigned PRESC_W   = $clog2(CLK_HZ / TICK_HZ)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_run,
  input  logic       i_load,
  input  logic [4:0] i_load_h,
  input  logic [5:0] i_load_m,
  input  logic [5:0] i_load_s,
  output logic       o_load_err,
  output logic [4:0] o_hours,
  output logic [5:0] o_minutes,
  output logic [5:0] o_seconds,
  output logic       o_sec_pulse,
  output logic       o_min_pulse,
  output logic       o_hour_pulse,
  output logic       o_day_pulse
`ifdef RTC_ALARM_EN
  ,
  input  logic [4:0] i_alarm_h,
  input  logic [5:0] i_alarm_m,
  input  logic       i_alarm_arm,
  input  logic       i_alarm_ack,
  output logic       o_alarm_ring
`endif
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;

  hms_t               w_load_t;
  logic               w_load_ok;
  logic               w_load_bad;
  logic               w_tick;
  logic               w_s_wrap;
  logic               w_m_wrap;
  logic               w_h_wrap;
  logic [PRESC_W-1:0] r_presc;
  logic               r_load_err;
  logic               r_sec_pulse;
  logic               r_min_pulse;
  logic               r_hour_pulse;
  logic               r_day_pulse;

  assign w_load_t   = '{h: i_load_h, m: i_load_m, s: i_load_s};
  assign w_load_ok  = i_load && hms_valid(w_load_t, HOURS_MAX);
  assign w_load_bad = i_load && !hms_valid(w_load_t, HOURS_MAX);
  // Any load request, accepted or not, takes precedence over the tick.
  assign w_tick     = i_run && !i_load && (r_presc == PRESC_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_load_ok) begin
      r_presc <= '0;
    end else if (i_run && !i_load) begin
      r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
    end
  end

  rtc_mod_counter #(.MOD(SEC_MAX), .W(6)) u_sec (
    .clk       (clk),
    .rst       (rst),
    .i_inc     (w_tick),
    .i_load    (w_load_ok),
    .i_load_val(i_load_s),
    .o_value   (o_seconds),
    .o_wrap    (w_s_wrap)
  );

  rtc_mod_counter #(.MOD(MIN_MAX), .W(6)) u_min (
    .clk       (clk),
    .rst       (rst),
    .i_inc     (w_s_wrap),
    .i_load    (w_load_ok),
    .i_load_val(i_load_m),
    .o_value   (o_minutes),
    .o_wrap    (w_m_wrap)
  );

  rtc_mod_counter #(.MOD(HOURS_MAX), .W(5)) u_hour (
    .clk       (clk),
    .rst       (rst),
    .i_inc     (w_m_wrap),
    .i_load    (w_load_ok),
    .i_load_val(i_load_h),
    .o_value   (o_hours),
    .o_wrap    (w_h_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_err   <= 1'b0;
      r_sec_pulse  <= 1'b0;
      r_min_pulse  <= 1'b0;
      r_hour_pulse <= 1'b0;
      r_day_pulse  <= 1'b0;
    end else begin
      r_load_err   <= w_load_bad;
      r_sec_pulse  <= w_tick;
      r_min_pulse  <= w_s_wrap;
      r_hour_pulse <= w_m_wrap;
      r_day_pulse  <= w_h_wrap;
    end
  end

  assign o_load_err   = r_load_err;
  assign o_sec_pulse  = r_sec_pulse;
  assign o_min_pulse  = r_min_pulse;
  assign o_hour_pulse = r_hour_pulse;
  assign o_day_pulse  = r_day_pulse;

`ifdef RTC_ALARM_EN
  hms_t w_next;
  logic w_alarm_hit;
  logic r_alarm_ring;

  // Time that becomes visible on the coming edge, for either a tick or an accepted load.
  always_comb begin
    w_next = w_load_t;
    if (!w_load_ok) begin
      w_next.s = w_s_wrap ? 6'd0 : o_seconds + 6'd1;
      w_next.m = w_m_wrap ? 6'd0 : (w_s_wrap ? o_minutes + 6'd1 : o_minutes);
      w_next.h = w_h_wrap ? 5'd0 : (w_m_wrap ? o_hours + 5'd1 : o_hours);
    end
  end

  assign w_alarm_hit = (w_load_ok || w_tick) &&
                       (w_next == '{h: i_alarm_h, m: i_alarm_m, s: 6'd0});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alarm_ring <= 1'b0;
    end else if (!i_alarm_arm) begin
      r_alarm_ring <= 1'b0;
    end else if (w_alarm_hit) begin
      r_alarm_ring <= 1'b1;
    end else if (i_alarm_ack) begin
      r_alarm_ring <= 1'b0;
    end
  end

  assign o_alarm_ring = r_alarm_ring;
`endif

endmodule

// File: tb/tb_rtc_hms_counter.sv
// Checks a 24-hour and a 12-hour rtc_hms_counter (DIV=10) against a seconds-of-day model.
// Alarm checks are included when RTC_ALARM_EN is defined.
module tb_rtc_hms_counter;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       load;
  logic [4:0] lh;
  logic [5:0] lm;
  logic [5:0] ls;

  logic [4:0] hrs  [2];
  logic [5:0] mins [2];
  logic [5:0] secs [2];
  logic       sp   [2];
  logic       mp   [2];
  logic       hp   [2];
  logic       dp   [2];
  logic       err  [2];

`ifdef RTC_ALARM_EN
  logic [4:0] ah;
  logic [5:0] am;
  logic       arm;
  logic       ack;
  logic       ring [2];
  bit         e_ring [2];
`endif

  int  hmax  [2] = '{24, 12};
  int  tsec  [2];
  int  phase [2];
  bit  e_sp [2], e_mp [2], e_hp [2], e_dp [2], e_err [2];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  rtc_hms_counter #(.CLK_HZ(10), .TICK_HZ(1), .HOURS_MAX(24)) u_dut24 (
    .clk         (clk),
    .rst         (rst),
    .i_run       (run),
    .i_load      (load),
    .i_load_h    (lh),
    .i_load_m    (lm),
    .i_load_s    (ls),
    .o_load_err  (err[0]),
    .o_hours     (hrs[0]),
    .o_minutes   (mins[0]),
    .o_seconds   (secs[0]),
    .o_sec_pulse (sp[0]),
    .o_min_pulse (mp[0]),
    .o_hour_pulse(hp[0]),
    .o_day_pulse (dp[0])
`ifdef RTC_ALARM_EN
    ,
    .i_alarm_h   (ah),
    .i_alarm_m   (am),
    .i_alarm_arm (arm),
    .i_alarm_ack (ack),
    .o_alarm_ring(ring[0])
`endif
  );

  rtc_hms_counter #(.CLK_HZ(10), .TICK_HZ(1), .HOURS_MAX(12)) u_dut12 (
    .clk         (clk),
    .rst         (rst),
    .i_run       (run),
    .i_load      (load),
    .i_load_h    (lh),
    .i_load_m    (lm),
    .i_load_s    (ls),
    .o_load_err  (err[1]),
    .o_hours     (hrs[1]),
    .o_minutes   (mins[1]),
    .o_seconds   (secs[1]),
    .o_sec_pulse (sp[1]),
    .o_min_pulse (mp[1]),
    .o_hour_pulse(hp[1]),
    .o_day_pulse (dp[1])
`ifdef RTC_ALARM_EN
    ,
    .i_alarm_h   (ah),
    .i_alarm_m   (am),
    .i_alarm_arm (arm),
    .i_alarm_ack (ack),
    .o_alarm_ring(ring[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: time as seconds-of-day, prescaler as a plain cycle phase.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit upd = 0;
      e_sp[d] = 0; e_mp[d] = 0; e_hp[d] = 0; e_dp[d] = 0; e_err[d] = 0;
      if (rst) begin
        tsec[d]  = 0;
        phase[d] = 0;
      end else if (load) begin
        if (int'(lh) < hmax[d] && int'(lm) < 60 && int'(ls) < 60) begin
          tsec[d]  = int'(lh) * 3600 + int'(lm) * 60 + int'(ls);
          phase[d] = 0;
          upd      = 1;
        end else begin
          e_err[d] = 1;
        end
      end else if (run) begin
        if (phase[d] == DIV - 1) begin
          phase[d] = 0;
          tsec[d]  = (tsec[d] + 1) % (hmax[d] * 3600);
          e_sp[d]  = 1;
          e_mp[d]  = (tsec[d] % 60) == 0;
          e_hp[d]  = (tsec[d] % 3600) == 0;
          e_dp[d]  = tsec[d] == 0;
          upd      = 1;
        end else begin
          phase[d]++;
        end
      end
`ifdef RTC_ALARM_EN
      if (rst || !arm) e_ring[d] = 0;
      else if (upd && tsec[d] == int'(ah) * 3600 + int'(am) * 60) e_ring[d] = 1;
      else if (ack) e_ring[d] = 0;
`else
      if (upd) begin end
`endif
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d.hours", d),   32'(hrs[d]),  32'(tsec[d] / 3600));
      chk($sformatf("d%0d.minutes", d), 32'(mins[d]), 32'((tsec[d] / 60) % 60));
      chk($sformatf("d%0d.seconds", d), 32'(secs[d]), 32'(tsec[d] % 60));
      chk($sformatf("d%0d.sec_pulse", d),  32'(sp[d]),  32'(e_sp[d]));
      chk($sformatf("d%0d.min_pulse", d),  32'(mp[d]),  32'(e_mp[d]));
      chk($sformatf("d%0d.hour_pulse", d), 32'(hp[d]),  32'(e_hp[d]));
      chk($sformatf("d%0d.day_pulse", d),  32'(dp[d]),  32'(e_dp[d]));
      chk($sformatf("d%0d.load_err", d),   32'(err[d]), 32'(e_err[d]));
`ifdef RTC_ALARM_EN
      chk($sformatf("d%0d.alarm_ring", d), 32'(ring[d]), 32'(e_ring[d]));
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load = 1'b1; lh = 5'(h); lm = 6'(m); ls = 6'(s);
    step();
    load = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b1; run = 1'b0; load = 1'b0; lh = '0; lm = '0; ls = '0;
`ifdef RTC_ALARM_EN
    ah = 5'd7; am = 6'd0; arm = 1'b0; ack = 1'b0;
`endif
    step();
    step();

    // Reset release with run=1: first tick DIV cycles later.
    run = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < DIV; i++) step();
    chk("t1.first_tick_sec", 32'(secs[0]), 32'd1);
    chk("t1.first_tick_pulse", 32'(sp[0]), 32'd1);
    step();
    chk("t1.no_double_pulse", 32'(sp[0]), 32'd0);

    // Full cascade 23:59:59 -> 00:00:00.
    do_load(23, 59, 58);
    for (int i = 0; i < 2 * DIV; i++) step();
    chk("t2.day_pulse", 32'(dp[0]), 32'd1);
    chk("t2.hours", 32'(hrs[0]), 32'd0);

    // Rejected loads, then a good one.
    do_load(24, 10, 10);
    chk("t3.err_h", 32'(err[0]), 32'd1);
    do_load(3, 60, 10);
    chk("t3.err_m", 32'(err[0]), 32'd1);
    do_load(12, 30, 0);
    chk("t3.load_min", 32'(mins[0]), 32'd30);
    chk("t3.load_noerr", 32'(err[0]), 32'd0);

    // Freeze mid-second, resume from held prescaler.
    for (int i = 0; i < 4; i++) step();
    run = 1'b0;
    for (int i = 0; i < 25; i++) step();
    run = 1'b1;
    for (int i = 0; i < DIV; i++) step();

    // Load coinciding with the terminal prescaler count.
    guard = 0;
    while (phase[0] != DIV - 1 && guard < 2 * DIV) begin
      step();
      guard++;
    end
    chk("t5.align_budget", 32'(guard < 2 * DIV), 32'd1);
    do_load(5, 6, 7);
    chk("t5.no_sec_pulse", 32'(sp[0]), 32'd0);
    chk("t5.loaded_sec", 32'(secs[0]), 32'd7);
    for (int i = 0; i < 14; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5.rst_sec", 32'(secs[0]), 32'd0);

    // 12-hour wrap on the second DUT, 24-hour continues to 12:00:00.
    do_load(11, 59, 59);
    for (int i = 0; i < DIV; i++) step();
    chk("t6.day12", 32'(dp[1]), 32'd1);
    chk("t6.hours24", 32'(hrs[0]), 32'd12);

`ifdef RTC_ALARM_EN
    ah = 5'd7; am = 6'd0; arm = 1'b1;
    do_load(6, 59, 59);
    for (int i = 0; i < DIV; i++) step();
    chk("t6.ring_set", 32'(ring[0]), 32'd1);
    for (int i = 0; i < 5; i++) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t6.ring_ack", 32'(ring[0]), 32'd0);
`endif

    // Randomised traffic around wrap points.
    for (int i = 0; i < 1500; i++) begin
      run  = ($urandom_range(0, 9) != 0);
      rst  = ($urandom_range(0, 299) == 0);
      load = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) begin
        lh = ($urandom_range(0, 1) == 1) ? 5'd23 : 5'd11;
        lm = 6'($urandom_range(58, 60));
        ls = 6'($urandom_range(55, 61));
      end else begin
        lh = 5'($urandom_range(0, 25));
        lm = 6'($urandom_range(0, 61));
        ls = 6'($urandom_range(0, 61));
      end
`ifdef RTC_ALARM_EN
      if ($urandom_range(0, 49) == 0) arm = ~arm;
      ack = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) begin
        ah = ($urandom_range(0, 1) == 1) ? 5'd0 : 5'd12;
        am = 6'd0;
      end
`endif
      step();
    end
    load = 1'b0;
    rst  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
